// File: rtl/piso_shift_tx.sv
// ---------------------------------------------------------------------------
// piso_shift_tx
//   Parallel-in/serial-out shift transmitter. A WIDTH-bit word is taken in
//   through a valid/ready load handshake. It is then sent on dout one bit per
//   clock. dout_valid marks every bit of the word, and last marks the final
//   bit. A new word can be accepted during the last-bit cycle, so consecutive
//   words are sent with no gap between them.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] goes out first, 0: din[0] goes out first
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   din         parallel word, captured only when a load is accepted
//   load_valid  producer offers din this cycle
//   load_ready  block can accept a word this cycle (driven from registers only)
//   dout        serial data bit (0 when idle)
//   dout_valid  dout carries a word bit this cycle
//   last        final bit of the current word
// ---------------------------------------------------------------------------
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             at_last;
  logic             accept;

  assign at_last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  // The ready signal comes only from registered state. This keeps the
  // handshake free of a combinational loop back to the producer.
  assign load_ready = (state_q == IDLE) || at_last;
  assign accept     = load_valid && load_ready;

  // Next-state logic
  always_comb begin
    // NOTE: assign a default to every always_comb output before any branch.
    // Otherwise a path that skips the assignment infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (at_last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment. Every register
    // then samples values from before the edge, whatever the block order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath. Reset has priority over a simultaneous accept.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is cleared on reset on purpose. dout is gated
    // while idle, but a known starting value keeps the outputs clean from
    // the first cycle after reset.
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      // din is sampled only here, so X on din while no load is accepted
      // never reaches the shift register.
      shreg_q <= din;
      cnt_q   <= '0;
    end else if (state_q == SHIFT) begin
      if (MSB_FIRST) shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
      // The counter returns to 0 at the end of a word and never wraps.
      cnt_q <= at_last ? '0 : cnt_q + CW'(1);
    end
  end

  // Outputs are decoded from registers only.
  assign dout_valid = (state_q == SHIFT);
  assign last       = at_last;
  assign dout       = dout_valid & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_piso_shift_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_tx
//   Testbench for piso_shift_tx. It drives three instances: WIDTH=4
//   MSB-first, WIDTH=4 LSB-first, and WIDTH=8 MSB-first. The stimulus
//   process pushes the hand-computed serial sequence {dout, last} into a
//   queue for each instance. A monitor for each instance pops one entry
//   whenever dout_valid is high and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din_a, din_b;
  logic [7:0] din_c;
  logic       lv_a, lv_b, lv_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       do_a, do_b, do_c;
  logic       dv_a, dv_b, dv_c;
  logic       last_a, last_b, last_c;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [1:0] q_c[$];

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .din(din_a), .load_valid(lv_a),
    .load_ready(rdy_a), .dout(do_a), .dout_valid(dv_a), .last(last_a));

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din_b), .load_valid(lv_b),
    .load_ready(rdy_b), .dout(do_b), .dout_valid(dv_b), .last(last_b));

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8 (
    .clk(clk), .reset(reset), .din(din_c), .load_valid(lv_c),
    .load_ready(rdy_c), .dout(do_c), .dout_valid(dv_c), .last(last_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, then settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // seq holds the serial order with the first emitted bit at seq[n-1].
  // The final bit carries last=1.
  task automatic push_exp(input int inst, input int n, input logic [7:0] seq);
    for (int i = n - 1; i >= 0; i--) begin
      logic [1:0] e;
      e = {seq[i], (i == 0)};
      case (inst)
        0: q_a.push_back(e);
        1: q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  // Monitors: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_bit", {do_a, last_a}, 32'hFF);
      else check("a_bit", {do_a, last_a}, q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dv_b === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_bit", {do_b, last_b}, 32'hFF);
      else check("b_bit", {do_b, last_b}, q_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dv_c === 1'b1) begin
      if (q_c.size() == 0) check("c_unexpected_bit", {do_c, last_c}, 32'hFF);
      else check("c_bit", {do_c, last_c}, q_c.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    din_a = 'x; din_b = 'x; din_c = 'x;
    lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;

    // 1: two reset cycles with no load offered. Din is X throughout.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_dv",    dv_a,   1'b0);
      check("rst_dout",  do_a,   1'b0);
      check("rst_last",  last_a, 1'b0);
      check("rst_ready", rdy_a,  1'b1);
    end
    reset = 1'b0;
    step();
    check("idle_dout_x_din", do_a, 1'b0);

    // 2: a single word 1011 goes out as 1,0,1,1 and last is set on bit 4.
    din_a = 4'b1011; lv_a = 1'b1;
    push_exp(0, 4, 8'b1011);
    step();
    lv_a = 1'b0; din_a = 'x;
    for (int i = 0; i < 4; i++) begin
      check("w1_dv", dv_a, 1'b1);
      check("w1_ready", rdy_a, (i == 3) ? 1'b1 : 1'b0);
      step();
    end
    check("w1_end_dv", dv_a, 1'b0);
    check("w1_end_ready", rdy_a, 1'b1);
    check("w1_end_dout", do_a, 1'b0);

    // 3: back-to-back words 1011 and 0110 give 8 valid bits in a row.
    din_a = 4'b1011; lv_a = 1'b1;
    push_exp(0, 4, 8'b1011);
    step();
    lv_a = 1'b0;
    step(); step();                       // now on bit 3
    step();                               // now on bit 4 (last)
    check("b2b_last_ready", rdy_a, 1'b1);
    din_a = 4'b0110; lv_a = 1'b1;
    push_exp(0, 4, 8'b0110);
    step();
    lv_a = 1'b0; din_a = 'x;
    for (int i = 0; i < 4; i++) begin
      check("b2b_dv", dv_a, 1'b1);
      step();
    end
    check("b2b_end_dv", dv_a, 1'b0);

    // 4: 1111 is offered early during word 0000. It must wait for bit 4.
    din_a = 4'b0000; lv_a = 1'b1;
    push_exp(0, 4, 8'b0000);
    step();                               // bit 1
    lv_a = 1'b0;
    step();                               // bit 2
    din_a = 4'b1111; lv_a = 1'b1;
    check("hold_ready_b2", rdy_a, 1'b0);
    step();                               // bit 3
    check("hold_ready_b3", rdy_a, 1'b0);
    check("hold_dout_b3", do_a, 1'b0);
    step();                               // bit 4
    check("hold_ready_b4", rdy_a, 1'b1);
    push_exp(0, 4, 8'b1111);
    step();
    lv_a = 1'b0; din_a = 'x;
    repeat (4) step();
    check("hold_end_dv", dv_a, 1'b0);

    // 5: reset after the second bit of 1011 aborts the word.
    din_a = 4'b1011; lv_a = 1'b1;
    push_exp(0, 2, 8'b10);                // only bits 1 and 2 are emitted
    q_a[q_a.size() - 1] = 2'b00;          // the aborted word has no last pulse
    step();                               // bit 1
    lv_a = 1'b0;
    step();                               // bit 2
    reset = 1'b1;
    step();
    check("abort_dv", dv_a, 1'b0);
    check("abort_last", last_a, 1'b0);
    check("abort_dout", do_a, 1'b0);
    check("abort_ready", rdy_a, 1'b1);
    reset = 1'b0;
    din_a = 4'b0001; lv_a = 1'b1;
    push_exp(0, 4, 8'b0001);
    step();
    lv_a = 1'b0; din_a = 'x;
    repeat (4) step();

    // 6a: LSB-first 1011 goes out as 1,1,0,1.
    din_b = 4'b1011; lv_b = 1'b1;
    push_exp(1, 4, 8'b1101);
    step();
    lv_b = 1'b0; din_b = 'x;
    repeat (4) step();
    check("lsb_end_dv", dv_b, 1'b0);

    // 6b: WIDTH=8 MSB-first A5 goes out as 1,0,1,0,0,1,0,1.
    din_c = 8'hA5; lv_c = 1'b1;
    push_exp(2, 8, 8'b1010_0101);
    step();
    lv_c = 1'b0; din_c = 'x;
    for (int i = 0; i < 8; i++) begin
      check("w8_ready", rdy_c, (i == 7) ? 1'b1 : 1'b0);
      step();
    end
    check("w8_end_dv", dv_c, 1'b0);

    // Every expected bit must have been consumed by the monitors.
    step();
    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    check("q_c_drained", q_c.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
